// File: rtl/ddr_burst_arbiter_if.sv
// ---------------------------------------------------------------------------
// ddr_burst_arbiter_if
//   Bundles the client-side request/response bus and the single DDR port of
//   the burst arbiter. Per-port fields are flattened; port i owns slice i.
//
//   Handshake: a client request (io_in_rd / io_in_wr) is taken on a rising
//   clock edge only while that port sees io_in_wait_n high. The DDR side
//   mirrors this: io_ddr_rd / io_ddr_wr are taken while io_ddr_wait_n is
//   high. Read data is qualified by io_ddr_valid and forwarded as
//   io_in_valid to the owning port; io_in_burstDone marks the last beat.
//
//   Modports:
//     slave  - the arbiter (consumes client requests, drives the DDR port)
//     master - the clients plus DDR controller (drive requests / responses)
// ---------------------------------------------------------------------------
interface ddr_burst_arbiter_if #(
    parameter int NUM_PORTS   = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int BURST_WIDTH = 8
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    // Client side
    logic [NUM_PORTS-1:0]             io_in_rd;
    logic [NUM_PORTS-1:0]             io_in_wr;
    logic [NUM_PORTS*ADDR_WIDTH-1:0]  io_in_addr;
    logic [NUM_PORTS*MASK_WIDTH-1:0]  io_in_mask;
    logic [NUM_PORTS*DATA_WIDTH-1:0]  io_in_din;
    logic [NUM_PORTS*BURST_WIDTH-1:0] io_in_burstLength;
    logic [DATA_WIDTH-1:0]            io_in_dout;
    logic [NUM_PORTS-1:0]             io_in_wait_n;
    logic [NUM_PORTS-1:0]             io_in_valid;
    logic [NUM_PORTS-1:0]             io_in_burstDone;
    logic [NUM_PORTS-1:0]             io_grant;

    // DDR side
    logic                             io_ddr_rd;
    logic                             io_ddr_wr;
    logic [ADDR_WIDTH-1:0]            io_ddr_addr;
    logic [MASK_WIDTH-1:0]            io_ddr_mask;
    logic [DATA_WIDTH-1:0]            io_ddr_din;
    logic [BURST_WIDTH-1:0]           io_ddr_burstLength;
    logic [DATA_WIDTH-1:0]            io_ddr_dout;
    logic                             io_ddr_wait_n;
    logic                             io_ddr_valid;

    modport slave (
        input  io_in_rd, io_in_wr, io_in_addr, io_in_mask, io_in_din,
               io_in_burstLength, io_ddr_dout, io_ddr_wait_n, io_ddr_valid,
        output io_in_dout, io_in_wait_n, io_in_valid, io_in_burstDone,
               io_grant, io_ddr_rd, io_ddr_wr, io_ddr_addr, io_ddr_mask,
               io_ddr_din, io_ddr_burstLength
    );

    modport master (
        output io_in_rd, io_in_wr, io_in_addr, io_in_mask, io_in_din,
               io_in_burstLength, io_ddr_dout, io_ddr_wait_n, io_ddr_valid,
        input  io_in_dout, io_in_wait_n, io_in_valid, io_in_burstDone,
               io_grant, io_ddr_rd, io_ddr_wr, io_ddr_addr, io_ddr_mask,
               io_ddr_din, io_ddr_burstLength
    );
endinterface

// File: rtl/ddr_burst_arbiter.sv
// ---------------------------------------------------------------------------
// ddr_burst_arbiter
//   Round-robin N-port burst arbiter in front of one DDR port. One port owns
//   the DDR port from acceptance until its burst completes; beats are counted
//   internally and the last beat is flagged to the owner only.
//
//   Ports:
//     clock       - sole clock, rising edge
//     reset       - synchronous, active-high
//     bus         - ddr_burst_arbiter_if.slave (client bus + DDR port)
//     dbg_state_o - current FSM state: 0 = IDLE, 1 = READ, 2 = WRITE
// ---------------------------------------------------------------------------
module ddr_burst_arbiter #(
    parameter int NUM_PORTS   = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int BURST_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    ddr_burst_arbiter_if.slave     bus,
    output logic [1:0]             dbg_state_o
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;
    localparam int PTR_WIDTH  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t                 state_q;
    logic [PTR_WIDTH-1:0]   owner_q;
    logic [PTR_WIDTH-1:0]   ptr_q;
    logic [BURST_WIDTH-1:0] cnt_q;
    logic [BURST_WIDTH-1:0] len_q;

    logic [NUM_PORTS-1:0]   req;
    logic                   cand_vld;
    logic [PTR_WIDTH-1:0]   cand;
    logic [NUM_PORTS-1:0]   cand_oh;
    logic [NUM_PORTS-1:0]   owner_oh;

    logic [PTR_WIDTH-1:0]   sel;
    logic                   sel_rd;
    logic                   sel_wr;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [MASK_WIDTH-1:0]  sel_mask;
    logic [DATA_WIDTH-1:0]  sel_din;
    logic [BURST_WIDTH-1:0] sel_len;

    logic                   accept;
    logic                   cnt_en;
    logic                   done;
    logic [BURST_WIDTH-1:0] len_eff;

    assign req         = bus.io_in_rd | bus.io_in_wr;
    assign dbg_state_o = state_q;

    // Rotating priority: search from ptr+1 upward. Iterating k downward lets
    // the closest requester overwrite farther ones.
    always_comb begin
        int idx;
        idx      = 0;
        cand_vld = 1'b0;
        cand     = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            idx = (int'(ptr_q) + k) % NUM_PORTS;
            if (req[idx]) begin
                cand_vld = 1'b1;
                cand     = PTR_WIDTH'(idx);
            end
        end
    end

    // Port whose fields drive DDR: the candidate in IDLE, the owner otherwise.
    always_comb begin
        sel      = (state_q == ST_IDLE) ? cand : owner_q;
        sel_rd   = 1'b0;
        sel_wr   = 1'b0;
        sel_addr = '0;
        sel_mask = '0;
        sel_din  = '0;
        sel_len  = '0;
        cand_oh  = '0;
        owner_oh = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (sel == PTR_WIDTH'(i)) begin
                sel_rd   = bus.io_in_rd[i];
                sel_wr   = bus.io_in_wr[i];
                sel_addr = bus.io_in_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_mask = bus.io_in_mask[i*MASK_WIDTH +: MASK_WIDTH];
                sel_din  = bus.io_in_din[i*DATA_WIDTH +: DATA_WIDTH];
                sel_len  = bus.io_in_burstLength[i*BURST_WIDTH +: BURST_WIDTH];
            end
            cand_oh[i]  = cand_vld && (cand == PTR_WIDTH'(i));
            owner_oh[i] = (owner_q == PTR_WIDTH'(i));
        end
    end

    always_comb begin
        bus.io_in_dout         = bus.io_ddr_dout;
        bus.io_ddr_rd          = 1'b0;
        bus.io_ddr_wr          = 1'b0;
        bus.io_ddr_addr        = '0;
        bus.io_ddr_mask        = '0;
        bus.io_ddr_din         = '0;
        bus.io_ddr_burstLength = len_q;
        bus.io_in_wait_n       = '0;
        bus.io_in_valid        = '0;
        bus.io_in_burstDone    = '0;
        bus.io_grant           = '0;
        accept                 = 1'b0;
        cnt_en                 = 1'b0;
        len_eff                = len_q;

        case (state_q)
            ST_IDLE: begin
                bus.io_ddr_burstLength = '0;
                if (cand_vld) begin
                    bus.io_ddr_rd          = sel_rd;
                    bus.io_ddr_wr          = sel_wr & ~sel_rd;
                    bus.io_ddr_addr        = sel_addr;
                    bus.io_ddr_mask        = sel_mask;
                    bus.io_ddr_din         = sel_din;
                    bus.io_ddr_burstLength = sel_len;
                    bus.io_in_wait_n       = cand_oh & {NUM_PORTS{bus.io_ddr_wait_n}};
                    len_eff                = sel_len;
                    accept                 = bus.io_ddr_wait_n;
                    // A write moves its first beat in the accepting cycle.
                    cnt_en                 = bus.io_ddr_wait_n & ~sel_rd;
                end
            end
            ST_READ: begin
                bus.io_ddr_addr  = sel_addr;
                bus.io_ddr_mask  = sel_mask;
                bus.io_ddr_din   = sel_din;
                bus.io_in_valid  = owner_oh & {NUM_PORTS{bus.io_ddr_valid}};
                bus.io_grant     = owner_oh;
                cnt_en           = bus.io_ddr_valid;
            end
            ST_WRITE: begin
                bus.io_ddr_wr    = sel_wr;
                bus.io_ddr_addr  = sel_addr;
                bus.io_ddr_mask  = sel_mask;
                bus.io_ddr_din   = sel_din;
                bus.io_in_wait_n = owner_oh & {NUM_PORTS{bus.io_ddr_wait_n}};
                bus.io_grant     = owner_oh;
                cnt_en           = sel_wr & bus.io_ddr_wait_n;
            end
            default: begin
            end
        endcase

        // len 0 is treated as a single beat; len-1 wraps modulo 2^BURST_WIDTH.
        done = cnt_en & ((cnt_q == len_eff - BURST_WIDTH'(1)) | (len_eff == '0));
        bus.io_in_burstDone = ((state_q == ST_IDLE) ? cand_oh : owner_oh)
                              & {NUM_PORTS{done}};

        if (reset) begin
            bus.io_ddr_rd       = 1'b0;
            bus.io_ddr_wr       = 1'b0;
            bus.io_in_wait_n    = '0;
            bus.io_in_valid     = '0;
            bus.io_in_burstDone = '0;
            bus.io_grant        = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= PTR_WIDTH'(NUM_PORTS - 1);
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        owner_q <= cand;
                        ptr_q   <= cand;
                        len_q   <= sel_len;
                        if (sel_rd) begin
                            state_q <= ST_READ;
                        end else if (done) begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= ST_WRITE;
                            cnt_q   <= cnt_q + BURST_WIDTH'(1);
                        end
                    end
                end
                ST_READ, ST_WRITE: begin
                    if (done) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_en) begin
                        cnt_q   <= cnt_q + BURST_WIDTH'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ddr_burst_arbiter
//   Directed scenarios plus a randomized run for ddr_burst_arbiter. Expected
//   outputs come from a transaction-level reference model (owner, last
//   granted port, beats remaining) evaluated once per cycle.
// ---------------------------------------------------------------------------
module tb_ddr_burst_arbiter;
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int MW = DW / 8;
    localparam int BW = 8;
    localparam int VW = 4*N + 2 + BW + AW + MW + 2*DW + 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] dbg_state;

    int vectors     = 0;
    int miscompares = 0;

    ddr_burst_arbiter_if #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                           .BURST_WIDTH(BW)) bus ();

    ddr_burst_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                        .BURST_WIDTH(BW)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    bit         m_active;
    bit         m_is_read;
    int         m_owner;
    int         m_last;
    int         m_left;
    logic [BW-1:0] m_len;
    int         m_cand;
    bit         m_acc;
    bit         m_beat;

    logic [N-1:0]  e_grant, e_wait, e_valid, e_done;
    logic          e_rd, e_wr;
    logic [BW-1:0] e_len;
    logic [AW-1:0] e_addr;
    logic [MW-1:0] e_mask;
    logic [DW-1:0] e_din, e_dout;
    logic [1:0]    e_state;

    logic [N-1:0] exp_q[$];

    function automatic logic [BW-1:0] raw_len(input int p);
        return bus.io_in_burstLength[p*BW +: BW];
    endfunction

    function automatic int beats(input int p);
        return (raw_len(p) == 0) ? 1 : int'(raw_len(p));
    endfunction

    function automatic void load_fields(input int p);
        e_addr = bus.io_in_addr[p*AW +: AW];
        e_mask = bus.io_in_mask[p*MW +: MW];
        e_din  = bus.io_in_din[p*DW +: DW];
    endfunction

    function automatic void model_eval();
        e_grant = '0; e_wait = '0; e_valid = '0; e_done = '0;
        e_rd = 1'b0; e_wr = 1'b0; e_len = '0; e_addr = '0; e_mask = '0; e_din = '0;
        e_dout  = bus.io_ddr_dout;
        e_state = !m_active ? 2'd0 : (m_is_read ? 2'd1 : 2'd2);
        m_cand = -1; m_acc = 1'b0; m_beat = 1'b0;
        if (reset) begin
            e_state = 2'd0;
            return;
        end
        if (!m_active) begin
            for (int k = 1; k <= N; k++) begin
                int p;
                p = (m_last + k) % N;
                if (m_cand < 0 && (bus.io_in_rd[p] || bus.io_in_wr[p])) m_cand = p;
            end
            if (m_cand >= 0) begin
                e_rd  = bus.io_in_rd[m_cand];
                e_wr  = bus.io_in_wr[m_cand] & ~bus.io_in_rd[m_cand];
                e_len = raw_len(m_cand);
                load_fields(m_cand);
                e_wait[m_cand] = bus.io_ddr_wait_n;
                if (bus.io_ddr_wait_n) begin
                    m_acc = 1'b1;
                    if (!bus.io_in_rd[m_cand] && beats(m_cand) == 1) e_done[m_cand] = 1'b1;
                end
            end
        end else begin
            e_grant[m_owner] = 1'b1;
            e_len = m_len;
            load_fields(m_owner);
            if (m_is_read) begin
                e_valid[m_owner] = bus.io_ddr_valid;
                m_beat = bus.io_ddr_valid;
            end else begin
                e_wr = bus.io_in_wr[m_owner];
                e_wait[m_owner] = bus.io_ddr_wait_n;
                m_beat = bus.io_in_wr[m_owner] && bus.io_ddr_wait_n;
            end
            if (m_beat && m_left == 1) e_done[m_owner] = 1'b1;
        end
    endfunction

    function automatic void model_commit();
        if (reset) begin
            m_active = 1'b0;
            m_last   = N - 1;
            return;
        end
        if (!m_active) begin
            if (m_acc) begin
                m_last  = m_cand;
                m_owner = m_cand;
                m_len   = raw_len(m_cand);
                if (bus.io_in_rd[m_cand]) begin
                    m_active  = 1'b1;
                    m_is_read = 1'b1;
                    m_left    = beats(m_cand);
                end else begin
                    m_is_read = 1'b0;
                    m_left    = beats(m_cand) - 1;
                    m_active  = (m_left > 0);
                end
            end
        end else if (m_beat) begin
            m_left--;
            if (m_left == 0) m_active = 1'b0;
        end
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {e_grant, e_rd, e_wr, e_wait, e_valid, e_done, e_len, e_addr,
                e_mask, e_din, e_dout, e_state};
    endfunction

    // During reset only the gated outputs and the read-data path are defined.
    function automatic logic [VW-1:0] obs_vec();
        if (reset)
            return {bus.io_grant, bus.io_ddr_rd, bus.io_ddr_wr, bus.io_in_wait_n,
                    bus.io_in_valid, bus.io_in_burstDone, {BW{1'b0}}, {AW{1'b0}},
                    {MW{1'b0}}, {DW{1'b0}}, bus.io_in_dout, 2'd0};
        return {bus.io_grant, bus.io_ddr_rd, bus.io_ddr_wr, bus.io_in_wait_n,
                bus.io_in_valid, bus.io_in_burstDone, bus.io_ddr_burstLength,
                bus.io_ddr_addr, bus.io_ddr_mask, bus.io_ddr_din, bus.io_in_dout,
                dbg_state};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [N-1:0] rd, input logic [N-1:0] wr,
                         input logic [N*BW-1:0] len, input logic wn, input logic vld);
        bus.io_in_rd          = rd;
        bus.io_in_wr          = wr;
        bus.io_in_burstLength = len;
        for (int p = 0; p < N; p++) begin
            bus.io_in_addr[p*AW +: AW] = $urandom;
            bus.io_in_mask[p*MW +: MW] = MW'($urandom);
            bus.io_in_din[p*DW +: DW]  = {$urandom, $urandom};
        end
        bus.io_ddr_dout   = {$urandom, $urandom};
        bus.io_ddr_wait_n = wn;
        bus.io_ddr_valid  = vld;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            drive('0, '0, '0, 1'b1, 1'b0);
            @(negedge clock);
            model_eval();
            model_commit();
            @(posedge clock);
            #1;
        end
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 2'b01, {8'd3, 8'd4}, 1'b1, 1'b1);
            @(negedge clock);
            model_eval();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL reset cyc %0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
            vectors++;
            if ({bus.io_ddr_rd, bus.io_ddr_wr, bus.io_in_wait_n, bus.io_in_valid,
                 bus.io_in_burstDone, bus.io_grant} !== '0) begin
                miscompares++;
                $display("FAIL reset_gated cyc %0d got=%b want=0", i,
                         {bus.io_ddr_rd, bus.io_ddr_wr, bus.io_in_wait_n,
                          bus.io_in_valid, bus.io_in_burstDone, bus.io_grant});
            end
            model_commit();
            @(posedge clock);
            #1;
        end
        reset = 1'b0;
        drive('0, '0, '0, 1'b1, 1'b1);
        @(negedge clock);
        model_eval();
        vectors++;
        if (dbg_state !== 2'd0 || bus.io_grant !== '0 || bus.io_in_valid !== '0) begin
            miscompares++;
            $display("FAIL reset_idle state=%0d grant=%b valid=%b want 0/00/00",
                     dbg_state, bus.io_grant, bus.io_in_valid);
        end
        model_commit();
        @(posedge clock);
        #1;
    endtask

    task automatic test_single_read();
        int nvalid0 = 0, nvalid1 = 0, ndone = 0, done_beat = -1;
        do_reset(2);
        for (int i = 0; i < 8; i++) begin
            // accept at cycle 0, valid beats on cycles 1,2,4,6
            drive((i == 0) ? 2'b01 : 2'b00, 2'b00, {8'd0, 8'd4}, 1'b1,
                  (i == 1 || i == 2 || i == 4 || i == 6));
            @(negedge clock);
            model_eval();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL single_read cyc %0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
            if (bus.io_in_valid[0]) nvalid0++;
            if (bus.io_in_valid[1]) nvalid1++;
            if (bus.io_in_burstDone[0]) begin ndone++; done_beat = nvalid0; end
            model_commit();
            @(posedge clock);
            #1;
        end
        vectors++;
        if (nvalid0 != 4 || nvalid1 != 0 || ndone != 1 || done_beat != 4) begin
            miscompares++;
            $display("FAIL single_read_tally valid0=%0d valid1=%0d done=%0d at_beat=%0d want 4/0/1/4",
                     nvalid0, nvalid1, ndone, done_beat);
        end
    endtask

    task automatic test_round_robin();
        int ndone = 0;
        do_reset(2);
        exp_q = {2'b01, 2'b10, 2'b01, 2'b10};
        for (int i = 0; i < 8; i++) begin
            drive(2'b00, 2'b11, {8'd2, 8'd2}, 1'b1, 1'b0);
            @(negedge clock);
            model_eval();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL round_robin cyc %0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
            if (bus.io_grant != '0) begin
                logic [N-1:0] want;
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                vectors++;
                if (bus.io_grant !== want) begin
                    miscompares++;
                    $display("FAIL rr_order cyc %0d got=%b want=%b", i, bus.io_grant, want);
                end
            end
            if (bus.io_in_burstDone != '0) ndone++;
            model_commit();
            @(posedge clock);
            #1;
        end
        vectors++;
        if (exp_q.size() != 0 || ndone != 4) begin
            miscompares++;
            $display("FAIL rr_tally grants_left=%0d done=%0d want 0/4", exp_q.size(), ndone);
        end
    endtask

    task automatic test_short_writes();
        logic [N-1:0] want_done[3] = '{2'b01, 2'b10, 2'b01};
        logic [N*BW-1:0] lens[3]   = '{{8'd0, 8'd0}, {8'd1, 8'd0}, {8'd0, 8'd1}};
        logic [N-1:0] wrs[3]       = '{2'b01, 2'b10, 2'b01};
        do_reset(2);
        for (int i = 0; i < 3; i++) begin
            drive(2'b00, wrs[i], lens[i], 1'b1, 1'b0);
            @(negedge clock);
            model_eval();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL short_write cyc %0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
            vectors++;
            if (bus.io_in_burstDone !== want_done[i] || dbg_state !== 2'd0) begin
                miscompares++;
                $display("FAIL short_write_done cyc %0d done=%b state=%0d want %b/0",
                         i, bus.io_in_burstDone, dbg_state, want_done[i]);
            end
            model_commit();
            @(posedge clock);
            #1;
        end
        drive('0, '0, '0, 1'b1, 1'b0);
        @(negedge clock);
        model_eval();
        vectors++;
        if (dbg_state !== 2'd0) begin
            miscompares++;
            $display("FAIL short_write_idle state=%0d want 0", dbg_state);
        end
        model_commit();
        @(posedge clock);
        #1;
    endtask

    task automatic test_wait_stall();
        int leak = 0;
        do_reset(2);
        for (int i = 0; i < 8; i++) begin
            drive(2'b00, 2'b11, {8'd4, 8'd4}, !(i >= 2 && i <= 4), 1'b0);
            @(negedge clock);
            model_eval();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL wait_stall cyc %0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
            if (i < 7) begin
                vectors++;
                if (bus.io_in_burstDone[0] !== (i == 6)) begin
                    miscompares++;
                    $display("FAIL wait_stall_done cyc %0d got=%b want=%b", i,
                             bus.io_in_burstDone[0], (i == 6));
                end
            end
            if (i >= 1 && i <= 6 && bus.io_in_wait_n[1]) leak++;
            model_commit();
            @(posedge clock);
            #1;
        end
        vectors++;
        if (leak != 0) begin
            miscompares++;
            $display("FAIL wait_stall_route port1_ready_cycles=%0d want 0", leak);
        end
    endtask

    task automatic test_rd_wr_same_port();
        do_reset(2);
        for (int i = 0; i < 4; i++) begin
            drive(2'b01, 2'b01, {8'd0, 8'd2}, 1'b1, (i == 1 || i == 2));
            @(negedge clock);
            model_eval();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL rd_wr cyc %0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
            if (i == 0) begin
                vectors++;
                if ({bus.io_ddr_rd, bus.io_ddr_wr} !== 2'b10) begin
                    miscompares++;
                    $display("FAIL rd_wr_ddr got rd/wr=%b want 10", {bus.io_ddr_rd, bus.io_ddr_wr});
                end
            end
            if (i == 1) begin
                vectors++;
                if (dbg_state !== 2'd1) begin
                    miscompares++;
                    $display("FAIL rd_wr_state got=%0d want 1", dbg_state);
                end
            end
            model_commit();
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset_mid_read();
        do_reset(2);
        for (int i = 0; i < 10; i++) begin
            reset = (i == 3 || i == 4);
            case (i)
                0:       drive(2'b01, 2'b00, {8'd4, 8'd4}, 1'b1, 1'b0);
                1, 2:    drive(2'b00, 2'b00, {8'd4, 8'd4}, 1'b1, 1'b1);
                3, 4:    drive(2'b11, 2'b00, {8'd4, 8'd4}, 1'b1, 1'b1);
                5, 6:    drive(2'b00, 2'b00, {8'd4, 8'd4}, 1'b1, 1'b1);
                default: drive(2'b11, 2'b00, {8'd1, 8'd1}, 1'b1, (i == 8));
            endcase
            @(negedge clock);
            model_eval();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL reset_mid cyc %0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
            if (i >= 3 && i <= 6) begin
                vectors++;
                if ({bus.io_ddr_rd, bus.io_ddr_wr, bus.io_in_valid, bus.io_in_burstDone,
                     bus.io_grant, bus.io_in_wait_n} !== '0) begin
                    miscompares++;
                    $display("FAIL reset_mid_quiet cyc %0d got=%b want=0", i,
                             {bus.io_ddr_rd, bus.io_ddr_wr, bus.io_in_valid,
                              bus.io_in_burstDone, bus.io_grant, bus.io_in_wait_n});
                end
            end
            if (i == 8) begin
                vectors++;
                if (bus.io_grant !== 2'b01) begin
                    miscompares++;
                    $display("FAIL reset_mid_first_grant got=%b want=01", bus.io_grant);
                end
            end
            model_commit();
            @(posedge clock);
            #1;
        end
        reset = 1'b0;
    endtask

    task automatic test_random();
        do_reset(2);
        for (int i = 0; i < 800; i++) begin
            logic [N*BW-1:0] len;
            for (int p = 0; p < N; p++) len[p*BW +: BW] = BW'($urandom_range(0, 5));
            reset = ($urandom_range(0, 99) == 0);
            drive(N'($urandom_range(0, 3) & $urandom_range(0, 3)), N'($urandom_range(0, 3)),
                  len, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1);
            @(negedge clock);
            model_eval();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cyc %0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
            model_commit();
            @(posedge clock);
            #1;
        end
        reset = 1'b0;
    endtask

    initial begin
        m_active = 1'b0;
        m_last   = N - 1;
        m_owner  = 0;
        m_left   = 0;
        m_len    = '0;
        drive('0, '0, '0, 1'b1, 1'b0);
        @(posedge clock);
        #1;
        test_reset();
        test_single_read();
        test_round_robin();
        test_short_writes();
        test_wait_stall();
        test_rd_wr_same_port();
        test_reset_mid_read();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
